// File: rtl/data_mem_if.sv
// Data-memory port bundle between the MEM stage (master) and the memory responder (slave).
// mem_err exists only when MEM_ALIGN_CHECK_EN is defined.
interface data_mem_if;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mem_err;
`endif

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall
`ifdef MEM_ALIGN_CHECK_EN
        , input mem_err
`endif
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall
`ifdef MEM_ALIGN_CHECK_EN
        , output mem_err
`endif
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM with a fixed number of wait states per access; stalls the pipeline while busy.
// Optional MEM_ALIGN_CHECK_EN: faults misaligned / out-of-range accesses and adds the mem_err pulse.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       cpu_rst_n,
    input  logic       cpu_en,
    data_mem_if.slave  mem
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_write_q;
    logic                   fault_q;
    logic [ADDR_WIDTH-1:0]  idx_q;
    logic [31:0]            wdata_q;
    logic [31:0]            din_q;
    logic [31:0]            ram [DEPTH];

    logic req_c, accept_c, finish_c, fault_c, stall_c, ram_we_c;
    logic unused_addr_c;

    assign req_c         = mem.mem_ren | mem.mem_wen;
    assign unused_addr_c = ^mem.mem_addr;

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;
    assign fault_c     = (mem.mem_addr[1:0] != 2'b00) || ((mem.mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign mem.mem_err = err_q;
`else
    assign fault_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (cpu_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and stall
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        finish_c = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_c = req_c;
                if (req_c && cpu_en) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_W'(WAIT_CYCLES);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cpu_en) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        finish_c = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_stall = stall_c;
    assign ram_we_c      = finish_c & is_write_q & ~fault_q;

    // Request capture at acceptance and read-data return at completion
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            is_write_q <= 1'b0;
            fault_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            din_q      <= '0;
        end else begin
            if (accept_c) begin
                is_write_q <= mem.mem_wen;
                fault_q    <= fault_c;
                idx_q      <= mem.mem_addr[ADDR_WIDTH+1:2];
                wdata_q    <= mem.mem_dout;
            end
            if (finish_c && !is_write_q) begin
                din_q <= fault_q ? 32'hDEAD_BEEF : ram[idx_q];
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Error pulse covers exactly the DONE cycle
    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            err_q <= 1'b0;
        end else if (cpu_en) begin
            err_q <= finish_c & fault_q;
        end
    end
`endif

    // RAM contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[idx_q] <= wdata_q;
        end
    end

    assign mem.mem_din = din_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus queues expected completions, a monitor checks each DONE cycle.
// Build with or without MEM_ALIGN_CHECK_EN.
module tb_data_mem_responder;
    localparam int unsigned W = 2;

    logic clk = 1'b0;
    logic cpu_rst_n;
    logic cpu_en;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    data_mem_if bus ();

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .cpu_rst_n (cpu_rst_n),
        .cpu_en    (cpu_en),
        .mem       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        chk_din;
        logic [31:0] din;
        int          len;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: a stall run followed by a low-stall cycle is the DONE cycle of one access
    int run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!cpu_rst_n) begin
            run = 0;
        end else if (bus.mem_stall) begin
            run++;
        end else if (run > 0) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_stall_len"}, 32'(run), 32'(e.len));
                if (e.chk_din) check({e.name, "_din"}, bus.mem_din, e.din);
`ifdef MEM_ALIGN_CHECK_EN
                check({e.name, "_err"}, 32'(bus.mem_err), 32'(e.err));
`endif
            end
            run = 0;
        end
    end

    // Issue one access, optionally freezing cpu_en for `gap` cycles mid-BUSY; returns after DONE
    task automatic access(input string name, input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_din, input int gap, input logic exp_err,
                          output int issue_cyc);
        exp_t e;
        bit   seen = 0;
        bit   done = 0;
        e.chk_din = 1'b1;
        e.din     = exp_din;
        e.len     = int'(W) + 1 + gap;
        e.err     = exp_err;
        e.name    = name;
        sb.push_back(e);
        issue_cyc    = cyc;
        bus.mem_ren  = ren;
        bus.mem_wen  = wen;
        bus.mem_addr = addr;
        bus.mem_dout = data;
        if (gap > 0) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            cpu_en = 1'b0;
            repeat (gap) @(posedge clk);
            #1 cpu_en = 1'b1;
        end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.mem_stall) seen = 1;
            else if (seen) done = 1;
        end
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.mem_ren = 1'b0;
        bus.mem_wen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1;
        logic exp_fault;
        cpu_rst_n    = 1'b0;
        cpu_en       = 1'b1;
        bus.mem_ren  = 1'b0;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = '0;
        bus.mem_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_din", bus.mem_din, 32'd0);
        check("reset_stall", 32'(bus.mem_stall), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("reset_err", 32'(bus.mem_err), 32'd0);
        exp_fault = 1'b1;
`else
        exp_fault = 1'b0;
`endif
        cpu_rst_n = 1'b1;
        @(posedge clk); #1;

        access("wr10", 1'b0, 1'b1, 32'h10, 32'h1234_5678, 32'h0, 0, 1'b0, c0);
        access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 0, 1'b0, c0);

        // Back-to-back writes: second must be accepted W+2 cycles after the first
        access("wr0", 1'b0, 1'b1, 32'h0, 32'hA, 32'h1234_5678, 0, 1'b0, c0);
        access("wr4", 1'b0, 1'b1, 32'h4, 32'hB, 32'h1234_5678, 0, 1'b0, c1);
        check("b2b_spacing", 32'(c1 - c0), 32'd4);
        access("rd0", 1'b1, 1'b0, 32'h0, 32'h0, 32'hA, 0, 1'b0, c0);
        access("rd4", 1'b1, 1'b0, 32'h4, 32'h0, 32'hB, 0, 1'b0, c0);

        access("rd10_en_gap", 1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 3, 1'b0, c0);

        // Reset in the middle of a write must discard it
        access("wr20", 1'b0, 1'b1, 32'h20, 32'h5, 32'h1234_5678, 0, 1'b0, c0);
        access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 32'h5, 0, 1'b0, c0);
        bus.mem_wen  = 1'b1;
        bus.mem_addr = 32'h20;
        bus.mem_dout = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("busy_before_reset", 32'(bus.mem_stall), 32'd1);
        cpu_rst_n   = 1'b0;
        bus.mem_wen = 1'b0;
        #1;
        check("midreset_din", bus.mem_din, 32'd0);
        check("midreset_stall", 32'(bus.mem_stall), 32'd0);
        @(posedge clk); #1;
        cpu_rst_n = 1'b1;
        @(posedge clk); #1;
        access("rd20_after_reset", 1'b1, 1'b0, 32'h20, 32'h0, 32'h5, 0, 1'b0, c0);

        // Both enables: write wins, mem_din untouched
        access("rw8", 1'b1, 1'b1, 32'h8, 32'h77, 32'h5, 0, 1'b0, c0);
        access("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 32'h77, 0, 1'b0, c0);

        // Alignment / range: aliased or faulted depending on build
        access("rd13", 1'b1, 1'b0, 32'h13, 32'h0,
               exp_fault ? 32'hDEAD_BEEF : 32'h1234_5678, 0, exp_fault, c0);
        access("rd1010", 1'b1, 1'b0, 32'h1010, 32'h0,
               exp_fault ? 32'hDEAD_BEEF : 32'h1234_5678, 0, exp_fault, c0);
        access("wr11", 1'b0, 1'b1, 32'h11, 32'h99,
               exp_fault ? 32'hDEAD_BEEF : 32'h1234_5678, 0, exp_fault, c0);
        access("rd10_after_wr11", 1'b1, 1'b0, 32'h10, 32'h0,
               exp_fault ? 32'h1234_5678 : 32'h99, 0, 1'b0, c0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
